// File: rtl/apb_arb_pkg.sv
// Shared types for the two-requester APB arbiter in front of the counter block.
package apb_arb_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // Requester index to its one-hot strobe position.
    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker. The pointer names the preferred requester; it
// flips to the loser of every grant so a lone requester never starves the other.
module rr_arbiter2
    import apb_arb_pkg::*;
(
    input  logic               pclk,
    input  logic               presetn,
    input  logic [NUM_REQ-1:0] elig,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_idx
);

    logic ptr;

    // Preferred requester wins when eligible, otherwise the other one does.
    always_comb begin
        grant_idx = ptr;
        if (!elig[ptr]) grant_idx = ~ptr;
        grant = '0;
        if (elig[grant_idx]) grant = idx_to_onehot(grant_idx);
    end

    // After a grant, prefer the requester that was not served.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn)     ptr <= 1'b0;
        else if (advance) ptr <= ~grant_idx;
    end

endmodule

// File: rtl/apb_counter_arbiter.sv
// Shares the counter's single APB slave port between two one-word requesters.
// Drives SETUP/ACCESS phases, bounds wait states with a timeout, and returns a
// one-cycle done strobe with read data and error flag to the granted requester.
module apb_counter_arbiter
    import apb_arb_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                      pclk,
    input  logic                      presetn,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         rdata,
    output logic                      err,
    output logic                      psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [ADDR_W-1:0]         paddr,
    output logic [DATA_W-1:0]         pwdata,
    input  logic [DATA_W-1:0]         prdata,
    input  logic                      pready
);

    // The counter only has to reach TIMEOUT_CYC-1: the next low cycle terminates.
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    state_t             state, state_nxt;
    logic [NUM_REQ-1:0] elig, grant;
    logic               gidx, gnt_q;
    logic [CNT_W-1:0]   wait_cnt;
    logic               start, finish, tmo, tmo_hit;

    // A requester whose done is high this cycle has already been served.
    assign elig    = req & ~done;
    assign tmo_hit = (TIMEOUT_CYC != 0) && (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

    rr_arbiter2 u_rr (
        .pclk      (pclk),
        .presetn   (presetn),
        .elig      (elig),
        .advance   (start),
        .grant     (grant),
        .grant_idx (gidx)
    );

    // Next-state and per-cycle transfer events.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        finish    = 1'b0;
        tmo       = 1'b0;
        case (state)
            IDLE: begin
                if (|grant) begin
                    start     = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: state_nxt = ACCESS;
            ACCESS: begin
                if (pready) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end else if (tmo_hit) begin
                    finish    = 1'b1;
                    tmo       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) state <= IDLE;
        else          state <= state_nxt;
    end

    // APB controls follow the next state; the command is latched only on grant.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            pwrite  <= 1'b0;
            paddr   <= '0;
            pwdata  <= '0;
            gnt_q   <= 1'b0;
        end else begin
            psel    <= (state_nxt != IDLE);
            penable <= (state_nxt == ACCESS);
            if (start) begin
                gnt_q  <= gidx;
                pwrite <= req_write[gidx];
                paddr  <= req_addr[ADDR_W*32'(gidx) +: ADDR_W];
                pwdata <= req_wdata[DATA_W*32'(gidx) +: DATA_W];
            end
        end
    end

    // Completion strobe; read data only for successful reads, zero otherwise.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            done  <= '0;
            rdata <= '0;
            err   <= 1'b0;
        end else begin
            done  <= finish ? idx_to_onehot(gnt_q) : '0;
            err   <= tmo;
            rdata <= (finish && !tmo && !pwrite) ? prdata : '0;
        end
    end

    // Counts pready-low ACCESS cycles; cleared whenever the transfer ends.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn)
            wait_cnt <= '0;
        else if (state == ACCESS && state_nxt == ACCESS && !pready)
            wait_cnt <= wait_cnt + CNT_W'(1);
        else if (state_nxt != ACCESS)
            wait_cnt <= '0;
    end

endmodule

// File: tb/tb_apb_counter_arbiter.sv
// Bench for apb_counter_arbiter: directed steps plus a randomized phase, all
// checked cycle by cycle against a transfer-level model of the arbiter.
module tb_apb_counter_arbiter;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int TMO    = 16;

    logic        pclk, presetn;
    logic [1:0]  req, req_write;
    logic [15:0] req_addr, req_wdata;
    logic [1:0]  done;
    logic [7:0]  rdata, paddr, pwdata, prdata;
    logic        err, psel, penable, pwrite, pready;
    logic [7:0]  a_addr [2];
    logic [7:0]  a_wdata[2];

    assign req_addr  = {a_addr[1], a_addr[0]};
    assign req_wdata = {a_wdata[1], a_wdata[0]};

    apb_counter_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TMO)) dut (
        .pclk(pclk), .presetn(presetn), .req(req), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .done(done), .rdata(rdata),
        .err(err), .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int n_chk, n_pass, n_fail;
    int cyc;
    // inputs as sampled at the previous edge
    logic [1:0] p_req, p_write;
    logic [7:0] p_addr[2], p_wdata[2], p_prdata;
    logic       p_pready;
    // transfer-level model
    int         m_ptr, m_cur, m_waits, m_acc_len, last_acc_len;
    bit         m_busy, m_access;
    logic [1:0] m_dprev;
    logic [7:0] m_paddr, m_pwdata;
    logic       m_pwrite;
    int         q_grant[$], q_setup[$], q_done[$];
    bit         pwrite_seen;
    // stimulus knobs
    int         rmode[2];
    int         pmode, acc_seen;
    bit         relaunch[2];
    bit         pfix;
    logic [7:0] pfix_val;
    logic [1:0] d_done;
    logic [7:0] d_rdata;
    logic       d_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cmd(input int i, input logic w, input logic [7:0] a, input logic [7:0] d);
        a_addr[i] = a; a_wdata[i] = d; req_write[i] = w; req[i] = 1'b1;
    endtask

    task automatic new_cmd(input int i);
        set_cmd(i, 1'($urandom), 8'($urandom), 8'($urandom));
    endtask

    // One clock: capture driven inputs, observe the following cycle, compare
    // against the model, then let requesters and slave react.
    task automatic cycle();
        logic [1:0] elig, e_done;
        logic [7:0] e_rdata;
        logic       e_err;
        int         win;
        bit         fin, tmo;
        p_req = req; p_write = req_write; p_addr = a_addr; p_wdata = a_wdata;
        p_pready = pready; p_prdata = prdata;
        @(posedge pclk); cyc++;
        @(negedge pclk);
        if (!presetn) begin
            chk("rst_psel",    32'(psel),    32'(0));
            chk("rst_penable", 32'(penable), 32'(0));
            chk("rst_done",    32'(done),    32'(0));
            chk("rst_err",     32'(err),     32'(0));
            chk("rst_rdata",   32'(rdata),   32'(0));
            chk("rst_paddr",   32'(paddr),   32'(0));
            chk("rst_pwdata",  32'(pwdata),  32'(0));
            m_busy = 0; m_access = 0; m_ptr = 0; m_dprev = 0;
            m_paddr = 0; m_pwdata = 0; m_pwrite = 0;
        end else begin
            fin = 0; tmo = 0;
            if (!m_busy) begin
                elig = p_req & ~m_dprev;
                if (elig != 2'b00) begin
                    win = elig[m_ptr] ? m_ptr : 1 - m_ptr;
                    m_ptr = 1 - win; m_cur = win; m_busy = 1; m_access = 0; m_waits = 0;
                    m_paddr = p_addr[win]; m_pwdata = p_wdata[win]; m_pwrite = p_write[win];
                    q_grant.push_back(win); q_setup.push_back(cyc);
                end
            end else if (!m_access) begin
                m_access = 1; m_acc_len = 1;
            end else if (p_pready) begin
                fin = 1;
            end else begin
                m_waits++;
                if (TMO != 0 && m_waits == TMO) begin fin = 1; tmo = 1; end
                else m_acc_len++;
            end
            e_done = 2'b00; e_rdata = 8'h00; e_err = 1'b0;
            if (fin) begin
                e_done  = (m_cur == 1) ? 2'b10 : 2'b01;
                e_rdata = (tmo || m_pwrite) ? 8'h00 : p_prdata;
                e_err   = tmo;
                m_busy = 0; m_access = 0; last_acc_len = m_acc_len;
                q_done.push_back(cyc);
            end
            m_dprev = e_done;
            chk("psel",    32'(psel),    32'(m_busy));
            chk("penable", 32'(penable), 32'(m_busy && m_access));
            chk("done",    32'(done),    32'(e_done));
            chk("rdata",   32'(rdata),   32'(e_rdata));
            chk("err",     32'(err),     32'(e_err));
            chk("paddr",   32'(paddr),   32'(m_paddr));
            chk("pwdata",  32'(pwdata),  32'(m_pwdata));
            chk("pwrite",  32'(pwrite),  32'(m_pwrite));
            if (psel && pwrite) pwrite_seen = 1;
        end
        for (int i = 0; i < 2; i++) begin
            case (rmode[i])
                0: if (done[i]) req[i] = 1'b0;
                1: begin
                    if (done[i]) begin req[i] = 1'b0; relaunch[i] = 1; end
                    else if (relaunch[i]) begin req[i] = 1'b1; relaunch[i] = 0; end
                end
                default: begin
                    if (done[i]) begin
                        if ($urandom_range(1, 0) == 1) new_cmd(i);
                        else req[i] = 1'b0;
                    end else if (!req[i] && $urandom_range(3, 0) == 0) new_cmd(i);
                end
            endcase
        end
        case (pmode)
            0: pready = 1'b1;
            1: pready = ($urandom_range(3, 0) != 0);
            2: pready = 1'b0;
            default: begin
                if (psel && penable) begin pready = (acc_seen >= 3); acc_seen++; end
                else begin pready = 1'b0; acc_seen = 0; end
            end
        endcase
        prdata = pfix ? pfix_val : 8'($urandom);
    endtask

    task automatic run_until_done(input int i, input int budget, output int dc);
        dc = -1;
        for (int k = 0; k < budget; k++) begin
            cycle();
            if (done[i]) begin
                dc = cyc; d_done = done; d_rdata = rdata; d_err = err;
                break;
            end
        end
        if (dc < 0) chk("done_wait", 32'(done[i]), 32'(1));
    endtask

    initial begin
        int t0, dc;
        n_chk = 0; n_pass = 0; n_fail = 0; cyc = 0;
        presetn = 1'b0; req = 2'b00; req_write = 2'b00; pready = 1'b1; prdata = 8'h00;
        a_addr = '{8'h00, 8'h00}; a_wdata = '{8'h00, 8'h00};
        rmode = '{0, 0}; pmode = 0; acc_seen = 0; relaunch = '{0, 0}; pfix = 0; pfix_val = 0;
        m_busy = 0; m_access = 0; m_ptr = 0; m_dprev = 0; m_paddr = 0; m_pwdata = 0; m_pwrite = 0;

        // reset values
        repeat (3) cycle();
        presetn = 1'b1;
        cycle();

        // single write, zero wait states
        q_setup.delete();
        set_cmd(0, 1'b1, 8'h04, 8'hA5); t0 = cyc;
        run_until_done(0, 10, dc);
        chk("wr_setup_cyc", 32'(q_setup.size() > 0 ? q_setup[0] : -1), 32'(t0 + 1));
        chk("wr_done_cyc",  32'(dc), 32'(t0 + 3));
        chk("wr_done_vec",  32'(d_done), 32'(2'b01));
        chk("wr_err",       32'(d_err), 32'(0));
        cycle();

        // single read from requester 1
        pfix = 1; pfix_val = 8'h3C; pwrite_seen = 0;
        set_cmd(1, 1'b0, 8'h08, 8'h00);
        run_until_done(1, 10, dc);
        chk("rd_done_vec", 32'(d_done), 32'(2'b10));
        chk("rd_rdata",    32'(d_rdata), 32'(8'h3C));
        chk("rd_pwrite",   32'(pwrite_seen), 32'(0));
        pfix = 0;
        cycle();

        // contention from reset: both requesters hold req, drop one cycle on done
        presetn = 1'b0; req = 2'b00;
        cycle(); cycle();
        presetn = 1'b1; rmode = '{1, 1};
        set_cmd(0, 1'b1, 8'h50, 8'h01); set_cmd(1, 1'b0, 8'h51, 8'h00);
        q_grant.delete(); q_setup.delete(); q_done.delete();
        for (int k = 0; k < 40 && q_grant.size() < 4; k++) cycle();
        chk("ctn_setups", 32'(q_grant.size()), 32'(4));
        for (int k = 0; k < 4; k++)
            chk("ctn_order", 32'(k < q_grant.size() ? q_grant[k] : 9), 32'(k % 2));
        for (int k = 0; k < 3; k++)
            chk("ctn_idle_gap",
                32'((k + 1 < q_setup.size() && k < q_done.size()) ? (q_setup[k+1] > q_done[k]) : 0),
                32'(1));
        rmode = '{0, 0}; relaunch = '{0, 0};
        repeat (15) cycle();

        // three wait states
        pmode = 3; acc_seen = 0;
        set_cmd(0, 1'b1, 8'h10, 8'h5A); t0 = cyc;
        run_until_done(0, 20, dc);
        chk("ws_done_cyc", 32'(dc), 32'(t0 + 6));
        chk("ws_acc_len",  32'(last_acc_len), 32'(4));
        pmode = 0;
        cycle();

        // randomized traffic with random wait states
        rmode = '{2, 2}; pmode = 1;
        repeat (400) cycle();
        rmode = '{0, 0}; pmode = 0;
        repeat (20) cycle();

        // timeout with pready stuck low
        pmode = 2;
        set_cmd(1, 1'b0, 8'h20, 8'h00); t0 = cyc;
        run_until_done(1, 40, dc);
        chk("tmo_done_cyc", 32'(dc), 32'(t0 + 18));
        chk("tmo_acc_len",  32'(last_acc_len), 32'(16));
        chk("tmo_err",      32'(d_err), 32'(1));
        chk("tmo_rdata",    32'(d_rdata), 32'(0));
        pmode = 0;
        cycle();

        // reset in the middle of ACCESS, with the pointer left at requester 1
        set_cmd(0, 1'b1, 8'h30, 8'h11);
        run_until_done(0, 10, dc);
        cycle();
        pmode = 2;
        set_cmd(0, 1'b1, 8'h31, 8'h22);
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (psel && penable) break;
        end
        chk("mr_in_access", 32'(penable), 32'(1));
        presetn = 1'b0; req = 2'b00;
        #1;
        chk("mr_async_psel",    32'(psel),    32'(0));
        chk("mr_async_penable", 32'(penable), 32'(0));
        chk("mr_async_done",    32'(done),    32'(0));
        cycle(); cycle();
        presetn = 1'b1; pmode = 0;
        set_cmd(0, 1'b0, 8'h40, 8'h00); set_cmd(1, 1'b1, 8'h41, 8'h77);
        q_grant.delete();
        run_until_done(0, 10, dc);
        chk("mr_grant", 32'(q_grant.size() > 0 ? q_grant[0] : 9), 32'(0));
        chk("mr_done",  32'(d_done), 32'(2'b01));
        chk("mr_err",   32'(d_err), 32'(0));
        repeat (10) cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
